// File: rtl/xor_link_pkg.sv
// Shared definitions for the XOR cipher link: default sizes, FSM encoding, count width helper.
package xor_link_pkg;
  localparam int KEY_SIZE_DEF  = 32;
  localparam int MSG_SIZE_DEF  = 512;
  localparam int WORD_SIZE_DEF = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/xor_key_rotator.sv
// Holds the decryption key and walks it MSB-first, wrapping every KEY_SIZE accepted bits.
module xor_key_rotator #(
  parameter int KEY_SIZE = 32
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic                iLoad,
  input  logic                iStart,
  input  logic                iAdv,
  output logic                oBit
);
  localparam int IW = $clog2(KEY_SIZE);
  localparam logic [IW-1:0] LAST = IW'(KEY_SIZE - 1);

  logic [KEY_SIZE-1:0] r_key;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx;

  // A start bit always uses key index 0, regardless of where the last frame stopped.
  assign w_idx = iStart ? '0 : r_idx;
  assign oBit  = r_key[LAST - w_idx];

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_key <= '0;
      r_idx <= '0;
    end else begin
      if (iLoad) r_key <= iKey;
      if (iAdv)  r_idx <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
    end
  end
endmodule

// File: rtl/xor_stream_rx.sv
// Cipher link receiver: framed serial ciphertext -> XOR decrypt -> plaintext words (valid/ready).
// Optional XOR_STREAM_RX_BYPASS_EN adds iBypass to pass a whole frame un-XORed.
module xor_stream_rx
  import xor_link_pkg::*;
#(
  parameter int KEY_SIZE  = KEY_SIZE_DEF,
  parameter int MSG_SIZE  = MSG_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [KEY_SIZE-1:0]           iKey,
  input  logic                          iKey_load,
  input  logic                          iSerial_in,
  input  logic                          iSerial_start,
  input  logic                          iSerial_end,
`ifdef XOR_STREAM_RX_BYPASS_EN
  input  logic                          iBypass,
`endif
  output logic [WORD_SIZE-1:0]          oPlain,
  output logic                          oPlain_valid,
  input  logic                          iPlain_ready,
  output logic                          oFrame_done,
  output logic                          oFrame_err,
  output logic [cnt_w(MSG_SIZE)-1:0]    oBit_count
);
  localparam int CW  = cnt_w(MSG_SIZE);
  localparam int WPW = $clog2(WORD_SIZE);

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_cur, w_cnt_nxt;
  logic [WPW-1:0]       r_wpos, w_wpos_cur;
  logic [WORD_SIZE-2:0] r_shift;
  logic [WORD_SIZE-1:0] r_plain, w_word;
  logic                 r_valid, r_done, r_err;
  logic                 w_acc, w_ovl, w_take, w_end, w_len_ok, w_len_err, w_done;
  logic                 w_wlast, w_wdone, w_free, w_overrun, w_abort, w_err_set;
  logic                 w_key_bit, w_byp, w_bit;

`ifdef XOR_STREAM_RX_BYPASS_EN
  logic r_bypass;
  assign w_byp = iSerial_start ? iBypass : r_bypass;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)               r_bypass <= 1'b0;
    else if (iSerial_start) r_bypass <= iBypass;
  end
`else
  assign w_byp = 1'b0;
`endif

  xor_key_rotator #(.KEY_SIZE(KEY_SIZE)) u_key (
    .iClk   (iClk),
    .iRst   (iRst),
    .iKey   (iKey),
    .iLoad  (iKey_load && (r_state == ST_IDLE)),
    .iStart (iSerial_start),
    .iAdv   (w_take),
    .oBit   (w_key_bit)
  );

  // A start bit restarts counting at bit 0 even when it aborts a frame in progress.
  assign w_acc      = (r_state == ST_RECV) || iSerial_start;
  assign w_ovl      = (r_state == ST_RECV) && !iSerial_start && (r_cnt == CW'(MSG_SIZE));
  assign w_take     = w_acc && !w_ovl;
  assign w_cnt_cur  = iSerial_start ? '0 : r_cnt;
  assign w_cnt_nxt  = w_cnt_cur + 1'b1;
  assign w_len_ok   = (w_cnt_nxt == CW'(MSG_SIZE));
  assign w_end      = w_take && iSerial_end;
  assign w_len_err  = w_end && !w_len_ok;
  assign w_done     = w_end && w_len_ok;

  assign w_bit      = iSerial_in ^ (w_key_bit & ~w_byp);
  assign w_wpos_cur = iSerial_start ? '0 : r_wpos;
  assign w_wlast    = (w_wpos_cur == WPW'(WORD_SIZE - 1));
  assign w_wdone    = w_take && w_wlast;
  assign w_word     = {r_shift, w_bit};

  // Single-word buffer: a slot frees on the same edge the held word is taken.
  assign w_free     = !r_valid || iPlain_ready;
  assign w_overrun  = w_wdone && !w_free;
  assign w_abort    = iSerial_start && (r_state == ST_RECV);
  assign w_err_set  = w_abort || w_len_err || w_ovl || w_overrun;

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) w_state_nxt = (iSerial_end || w_ovl) ? ST_IDLE : ST_RECV;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wpos  <= '0;
      r_shift <= '0;
      r_plain <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done;
      if (w_take) begin
        r_cnt   <= w_cnt_nxt;
        r_wpos  <= w_wlast ? '0 : w_wpos_cur + 1'b1;
        r_shift <= w_word[WORD_SIZE-2:0];
      end
      if (w_wdone && w_free) begin
        r_plain <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && iPlain_ready) begin
        r_valid <= 1'b0;
      end
      if (w_err_set)          r_err <= 1'b1;
      else if (iSerial_start) r_err <= 1'b0;
    end
  end

  assign oPlain       = r_plain;
  assign oPlain_valid = r_valid;
  assign oFrame_done  = r_done;
  assign oFrame_err   = r_err;
  assign oBit_count   = r_cnt;
endmodule

// File: tb/tb_xor_stream_rx.sv
// Directed bench for xor_stream_rx with default sizes (key 32, frame 512, word 8).
module tb_xor_stream_rx;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iKey = '0;
  logic        iKey_load = 1'b0;
  logic        iSerial_in = 1'b0;
  logic        iSerial_start = 1'b0;
  logic        iSerial_end = 1'b0;
  logic        iPlain_ready = 1'b1;
  logic [7:0]  oPlain;
  logic        oPlain_valid;
  logic        oFrame_done;
  logic        oFrame_err;
  logic [9:0]  oBit_count;

  xor_stream_rx dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iKey          (iKey),
    .iKey_load     (iKey_load),
    .iSerial_in    (iSerial_in),
    .iSerial_start (iSerial_start),
    .iSerial_end   (iSerial_end),
    .oPlain        (oPlain),
    .oPlain_valid  (oPlain_valid),
    .iPlain_ready  (iPlain_ready),
    .oFrame_done   (oFrame_done),
    .oFrame_err    (oFrame_err),
    .oBit_count    (oBit_count)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0]   q[$];
  logic [511:0] c_zero, c_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge iClk);
    #1;
    if (oPlain_valid === 1'b1 && iPlain_ready) q.push_back(oPlain);
    if (oFrame_done === 1'b1) done_cnt++;
  endtask

  task automatic send_range(input logic [511:0] cv, input int from, input int to, input bit do_end);
    for (int i = from; i <= to; i++) begin
      iSerial_in    = cv[511-i];
      iSerial_start = (i == 0);
      iSerial_end   = do_end && (i == to);
      tick();
    end
    iSerial_in = 1'b0; iSerial_start = 1'b0; iSerial_end = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k);
    iKey = k; iKey_load = 1'b1;
    tick();
    iKey_load = 1'b0;
  endtask

  initial begin
    int m;
    logic [31:0] k2;
    logic [7:0]  pb;
    c_zero = '0;
    k2 = 32'h01234567;
    for (int i = 0; i < 512; i++) begin
      pb = 8'(i / 8);
      c_cnt[511-i] = pb[7 - (i % 8)] ^ k2[31 - (i % 32)];
    end

    // Reset state
    tick(); tick();
    chk("rst_plain", {24'd0, oPlain}, 32'h0);
    chk("rst_valid", {31'd0, oPlain_valid}, 32'h0);
    chk("rst_done", {31'd0, oFrame_done}, 32'h0);
    chk("rst_err", {31'd0, oFrame_err}, 32'h0);
    chk("rst_count", {22'd0, oBit_count}, 32'h0);
    iRst = 1'b0;
    tick();

    // T1: zero ciphertext -> key bytes
    load_key(32'hA5A5A5A5);
    q.delete(); done_cnt = 0;
    send_range(c_zero, 0, 511, 1'b1);
    chk("t1_done_pulse", {31'd0, oFrame_done}, 32'h1);
    chk("t1_last_valid", {31'd0, oPlain_valid}, 32'h1);
    tick();
    chk("t1_done_1cyc", {31'd0, oFrame_done}, 32'h0);
    m = 0;
    foreach (q[i]) if (q[i] !== 8'hA5) m++;
    chk("t1_words", q.size(), 64);
    chk("t1_word_mism", m, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", {31'd0, oFrame_err}, 32'h0);

    // T2: counting plaintext through key 0x01234567
    load_key(k2);
    q.delete(); done_cnt = 0;
    send_range(c_cnt, 0, 511, 1'b1);
    tick();
    m = 0;
    foreach (q[i]) if (q[i] !== 8'(i)) m++;
    chk("t2_words", q.size(), 64);
    chk("t2_word_mism", m, 0);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_err", {31'd0, oFrame_err}, 32'h0);

    // T3: short frame ending at bit 100
    q.delete(); done_cnt = 0;
    send_range(c_zero, 0, 100, 1'b1);
    tick(); tick();
    chk("t3_words", q.size(), 12);
    chk("t3_first", {24'd0, q[0]}, 32'h01);
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_err", {31'd0, oFrame_err}, 32'h1);
    send_range(c_zero, 0, 0, 1'b0);
    chk("t3_start_clears_err", {31'd0, oFrame_err}, 32'h0);
    chk("t3_count_1", {22'd0, oBit_count}, 32'h1);
    iSerial_end = 1'b1; tick(); iSerial_end = 1'b0;
    chk("t3_len2_err", {31'd0, oFrame_err}, 32'h1);

    // T4: overrun with ready held low for two words
    load_key(32'h12345678);
    q.delete();
    iPlain_ready = 1'b0;
    send_range(c_zero, 0, 15, 1'b0);
    chk("t4_held_word", {24'd0, oPlain}, 32'h12);
    chk("t4_held_valid", {31'd0, oPlain_valid}, 32'h1);
    chk("t4_overrun_err", {31'd0, oFrame_err}, 32'h1);
    iPlain_ready = 1'b1;
    send_range(c_zero, 16, 511, 1'b1);
    tick();
    chk("t4_words", q.size(), 62);
    chk("t4_q0", {24'd0, q[0]}, 32'h56);
    chk("t4_q1", {24'd0, q[1]}, 32'h78);
    chk("t4_err_end", {31'd0, oFrame_err}, 32'h1);

    // T5: reset in the middle of a frame
    load_key(32'hA5A5A5A5);
    send_range(c_zero, 0, 299, 1'b0);
    chk("t5_count_300", {22'd0, oBit_count}, 32'd300);
    iRst = 1'b1;
    #1;
    chk("t5_async_count", {22'd0, oBit_count}, 32'h0);
    tick();
    chk("t5_plain", {24'd0, oPlain}, 32'h0);
    chk("t5_valid", {31'd0, oPlain_valid}, 32'h0);
    chk("t5_err", {31'd0, oFrame_err}, 32'h0);
    iRst = 1'b0;
    tick();
    iSerial_in = 1'b1; iSerial_end = 1'b1; tick();
    iSerial_in = 1'b0; iSerial_end = 1'b0;
    chk("t5_idle_end_ign_err", {31'd0, oFrame_err}, 32'h0);
    chk("t5_idle_end_ign_cnt", {22'd0, oBit_count}, 32'h0);
    load_key(32'hA5A5A5A5);
    q.delete(); done_cnt = 0;
    send_range(c_zero, 0, 511, 1'b1);
    tick();
    m = 0;
    foreach (q[i]) if (q[i] !== 8'hA5) m++;
    chk("t5_words", q.size(), 64);
    chk("t5_word_mism", m, 0);
    chk("t5_done_cnt", done_cnt, 1);

    // T6: key load ignored mid-frame; start while receiving aborts
    load_key(k2);
    q.delete();
    send_range(c_cnt, 0, 39, 1'b0);
    iKey = 32'hFFFFFFFF; iKey_load = 1'b1;
    send_range(c_cnt, 40, 40, 1'b0);
    iKey_load = 1'b0;
    send_range(c_cnt, 41, 511, 1'b1);
    tick();
    m = 0;
    foreach (q[i]) if (q[i] !== 8'(i)) m++;
    chk("t6_words", q.size(), 64);
    chk("t6_old_key_mism", m, 0);
    chk("t6_err0", {31'd0, oFrame_err}, 32'h0);
    q.delete();
    send_range(c_cnt, 0, 99, 1'b0);
    send_range(c_cnt, 0, 0, 1'b0);
    chk("t6_abort_err", {31'd0, oFrame_err}, 32'h1);
    chk("t6_restart_cnt", {22'd0, oBit_count}, 32'h1);
    send_range(c_cnt, 1, 511, 1'b1);
    tick();
    m = 0;
    for (int i = 0; i < 64; i++) if (q.size() < 76 || q[12+i] !== 8'(i)) m++;
    chk("t6_restart_words", q.size(), 76);
    chk("t6_restart_mism", m, 0);
    chk("t6_err_kept", {31'd0, oFrame_err}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
